// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields and an immediate into R/I/S/B/U/J words with sequential addresses.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int INSTRUCTION = 32,
    parameter int ADDR_W      = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             fmt,
    input  logic [6:0]             opcode,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [2:0]             funct3,
    input  logic [6:0]             funct7,
    input  logic [INSTRUCTION-1:0] imm,
    input  logic                   restart,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTRUCTION-1:0] instruction,
    output logic [ADDR_W-1:0]      out_addr,
    output logic                   imm_err
);

    localparam logic [INSTRUCTION-1:0] NOP = 32'h0000_0013;

    logic [INSTRUCTION-1:0] enc_word;
    logic                   fmt_illegal;
    logic                   range_err;
    logic [ADDR_W-1:0]      counter;
    logic                   accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        enc_word    = NOP;
        fmt_illegal = 1'b0;
        case (fmt)
            3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            3'd4: enc_word = {imm[31:12], rd, opcode};
            3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: fmt_illegal = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Immediate must sign-extend cleanly from its field width; branch/jump offsets must be even.
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            3'd1, 3'd2: range_err = !((&imm[31:11]) || !(|imm[31:11]));
            3'd3:       range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            3'd4:       range_err = |imm[11:0];
            3'd5:       range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default:    range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            instruction <= '0;
            out_addr    <= '0;
            imm_err     <= 1'b0;
            counter     <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            instruction <= enc_word;
            imm_err     <= fmt_illegal || range_err;
            out_addr    <= restart ? '0 : counter;
            counter     <= restart ? ADDR_W'(1) : counter + ADDR_W'(1);
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (restart)
                counter <= '0;
        end
    end

endmodule
